stream_packer: RTL and testbench
================================

STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 64, meaning width of one input beat in bits.
REQ-002 SHALL have parameter RATIO, default 8, meaning input beats per output word; power of two, at least 2.
REQ-003 SHALL have parameter TIMEOUT, default 256, meaning idle cycles before an automatic partial flush; at least 1.
REQ-004 SHALL have port clk_i, input, 1, clock.
REQ-005 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port flush_i, input, 1, request to emit the partially filled word.
REQ-007 SHALL have port in_data_i, input, IN_WIDTH, input beat, driven from the CDC FIFO destination side.
REQ-008 SHALL have port in_valid_i, input, 1, input beat valid.
REQ-009 SHALL have port in_ready_o, output, 1, input beat accepted when high together with in_valid_i.
REQ-010 SHALL have port out_data_o, output, IN_WIDTH*RATIO, packed output word.
REQ-011 SHALL have port out_mask_o, output, RATIO, lane-valid mask; bit i covers lane i.
REQ-012 SHALL have port out_valid_o, output, 1, output word valid.
REQ-013 SHALL have port out_ready_i, input, 1, downstream ready.

Function
REQ-014 SHALL write the k-th accepted beat of a word into lane k (bits k*IN_WIDTH +: IN_WIDTH); lane 0 is the LSBs.
REQ-015 SHALL keep an accumulation buffer with a lane count cnt (range 0..RATIO) and one output register, so accumulation continues while the output stalls.
REQ-016 SHALL close a word when lane RATIO-1 is written, or on a flush with cnt>0 (cnt counted after any same-cycle beat).
REQ-017 SHALL move a closed word to the output register on the same edge if the slot is free (out_valid_o low, or out_ready_i high); otherwise the word waits in the buffer with cnt held.
REQ-018 SHALL raise out_valid_o the cycle after the handshake or flush that closed the word, provided the slot is free.
REQ-019 SHALL drive in_ready_o low while a closed word waits in the buffer, and high otherwise.
REQ-020 SHALL hold out_data_o and out_mask_o stable while out_valid_o is high and out_ready_i is low.
REQ-021 SHALL drive unfilled lanes of out_data_o to zero; out_mask_o SHALL equal (1<<cnt)-1 at closure.
REQ-022 SHALL include in the flushed word a beat accepted in the same cycle as flush_i.
REQ-023 SHALL ignore flush_i when cnt==0 and no beat is accepted; it SHALL produce no output and no zero-mask word.
REQ-024 SHALL register a flush that arrives while the output slot is busy as pending; the pending flush SHALL close on the first free cycle, with in_ready_o low until then.
REQ-025 SHALL sustain full throughput: one beat per cycle, and a full word every RATIO cycles, when out_ready_i is held high.

Reset
REQ-026 SHALL, on rst_ni low, asynchronously clear cnt, the pending flush, the idle counter, out_valid_o, out_data_o and out_mask_o to 0.
REQ-027 SHALL hold in_ready_o at 0 while rst_ni is low and drive it to 1 on the first cycle after reset release.
REQ-028 SHALL discard any partial word on reset mid-operation and SHALL NOT emit it.

Configuration
REQ-029 SHALL use macro STREAM_PACKER_TIMEOUT_EN to gate the automatic flush.
REQ-030 SHALL, with STREAM_PACKER_TIMEOUT_EN defined, count consecutive cycles with cnt>0 and no accepted beat, reset the count on any accepted beat or word closure, and treat the count reaching TIMEOUT exactly as flush_i.
REQ-031 SHALL, without STREAM_PACKER_TIMEOUT_EN, have no idle counter logic; partial words SHALL leave only via flush_i.

Verification (IN_WIDTH=64, RATIO=8, TIMEOUT=16)
REQ-032 SHALL cover: beats 0x0..0x7 back-to-back, out_ready_i=1 -> one word, lane k=k, mask 0xFF, out_valid_o high exactly 1 cycle after the 8th handshake.
REQ-033 SHALL cover: 3 beats, then flush_i pulse -> mask 0x07, lanes 3..7 zero; a second flush with cnt=0 -> no output.
REQ-034 SHALL cover: out_ready_i=0, 16 beats offered -> the 1st word is held stable, the 2nd word fills the buffer, in_ready_o=0 from the 17th offer; out_ready_i=1 -> both words emitted in order, no beat lost.
REQ-035 SHALL cover: flush_i in the same cycle as the 5th beat -> mask 0x1F, lane 4 holds that beat.
REQ-036 SHALL cover, with STREAM_PACKER_TIMEOUT_EN defined: 2 beats, then idle -> mask 0x03 word emitted after 16 idle cycles; with the macro undefined, no output after 100 idle cycles.
REQ-037 SHALL cover: rst_ni pulsed low after 4 beats -> out_valid_o=0; the next 8 beats form a fresh word with mask 0xFF, lane 0 = first post-reset beat.

Source files
------------

// File: rtl/stream_packer.sv
// Packs RATIO narrow input beats into one wide output word, with partial-word flush.
// Optional idle-timeout auto-flush is built when STREAM_PACKER_TIMEOUT_EN is defined.
module stream_packer #(
  parameter int IN_WIDTH = 64,
  parameter int RATIO    = 8,
  parameter int TIMEOUT  = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic [IN_WIDTH-1:0]       in_data_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  output logic [IN_WIDTH*RATIO-1:0] out_data_o,
  output logic [RATIO-1:0]          out_mask_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CW        = $clog2(RATIO + 1);

  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("stream_packer: RATIO must be a power of two >= 2 and TIMEOUT >= 1");
  end

  logic [CW-1:0]        cnt_q;
  logic                 flush_pend_q;
  logic                 run_q;
  logic [OUT_WIDTH-1:0] buf_q;

  logic                 accept;
  logic [CW-1:0]        cnt_add;
  logic [OUT_WIDTH-1:0] buf_add;
  logic [OUT_WIDTH-1:0] word_add;
  logic [RATIO-1:0]     mask_add;
  logic                 waiting;
  logic                 full_now;
  logic                 flush_req;
  logic                 close_now;
  logic                 slot_free;
  logic                 move;
  logic                 timeout_hit;

  // A closed word waiting in the buffer is either full (cnt==RATIO) or a pending flush.
  assign waiting    = (cnt_q == CW'(RATIO)) | flush_pend_q;
  assign in_ready_o = run_q & ~waiting;
  assign accept     = in_valid_i & in_ready_o;
  assign cnt_add    = cnt_q + CW'(accept);
  assign full_now   = (cnt_add == CW'(RATIO));
  assign flush_req  = flush_i | timeout_hit;
  assign close_now  = waiting | full_now | (flush_req & (cnt_add != '0));
  assign slot_free  = ~out_valid_o | out_ready_i;
  assign move       = close_now & slot_free;

  always_comb begin
    buf_add  = buf_q;
    word_add = '0;
    mask_add = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (accept && cnt_q == CW'(i)) begin
        buf_add[i*IN_WIDTH +: IN_WIDTH] = in_data_i;
      end
    end
    // Stale lanes from the previous word stay in buf_q; masking zeroes them on output.
    for (int i = 0; i < RATIO; i++) begin
      mask_add[i] = (CW'(i) < cnt_add);
      if (mask_add[i]) begin
        word_add[i*IN_WIDTH +: IN_WIDTH] = buf_add[i*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      buf_q        <= '0;
      out_valid_o  <= 1'b0;
      out_data_o   <= '0;
      out_mask_o   <= '0;
    end else begin
      buf_q <= buf_add;
      if (move) begin
        out_data_o   <= word_add;
        out_mask_o   <= mask_add;
        out_valid_o  <= 1'b1;
        cnt_q        <= '0;
        flush_pend_q <= 1'b0;
      end else begin
        out_valid_o  <= out_valid_o & ~out_ready_i;
        cnt_q        <= cnt_add;
        flush_pend_q <= flush_pend_q | (close_now & ~full_now);
      end
    end
  end

`ifdef STREAM_PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_q;
  logic          idle;

  // Down-counter reloads on any activity; terminal count in an idle cycle acts as flush_i.
  assign idle        = (cnt_q != '0) & ~accept & ~waiting;
  assign timeout_hit = idle & (idle_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_q <= '0;
    end else if (idle && idle_q != '0) begin
      idle_q <= idle_q - TW'(1);
    end else begin
      idle_q <= TW'(TIMEOUT - 1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_stream_packer.sv
// Directed self-checking bench for stream_packer (IN_WIDTH=64, RATIO=8, TIMEOUT=16).
module tb_stream_packer;

  localparam int W = 64;
  localparam int R = 8;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           flush_i = 1'b0;
  logic [W-1:0]   in_data_i = '0;
  logic           in_valid_i = 1'b0;
  logic           in_ready_o;
  logic [W*R-1:0] out_data_o;
  logic [R-1:0]   out_mask_o;
  logic           out_valid_o;
  logic           out_ready_i = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  stream_packer #(.IN_WIDTH(W), .RATIO(R), .TIMEOUT(16)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_mask_o  (out_mask_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [W*R-1:0] got, input logic [W*R-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected word: lanes 0..n-1 hold base+k, remaining lanes zero.
  function automatic logic [W*R-1:0] pack(input logic [W-1:0] base, input int n);
    logic [W*R-1:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[k*W +: W] = base + W'(k);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    int n;
    n = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    @(negedge clk_i);
    while (!in_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("send_ready", in_ready_o, 1'b1);
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic send_n(input logic [W-1:0] base, input int n);
    for (int k = 0; k < n; k++) send(base + W'(k));
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  initial begin
    int lat;
    bit seen;

    // Reset state
    #12;
    check("rst_in_ready", in_ready_o, 1'b0);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_out_mask", out_mask_o, '0);
    check("rst_out_data", out_data_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready_o, 1'b1);

    // Full word back-to-back
    out_ready_i = 1'b1;
    send_n(64'h0, 7);
    check("full_before_8th", out_valid_o, 1'b0);
    send(64'h7);
    check("full_valid", out_valid_o, 1'b1);
    check("full_mask", out_mask_o, 8'hFF);
    check("full_data", out_data_o, pack(64'h0, 8));
    tick();
    check("full_consumed", out_valid_o, 1'b0);

    // Partial flush, then flush with nothing buffered
    send_n(64'hA0, 3);
    pulse_flush();
    check("flush3_valid", out_valid_o, 1'b1);
    check("flush3_mask", out_mask_o, 8'h07);
    check("flush3_data", out_data_o, pack(64'hA0, 3));
    tick();
    check("flush3_consumed", out_valid_o, 1'b0);
    pulse_flush();
    tick();
    tick();
    check("empty_flush_no_out", out_valid_o, 1'b0);
    check("empty_flush_ready", in_ready_o, 1'b1);

    // Backpressure: two words, then release
    out_ready_i = 1'b0;
    send_n(64'h100, 8);
    check("bp_a_valid", out_valid_o, 1'b1);
    check("bp_a_data", out_data_o, pack(64'h100, 8));
    send_n(64'h200, 8);
    check("bp_buffer_full", in_ready_o, 1'b0);
    in_valid_i = 1'b1;
    in_data_i  = 64'hC0;
    @(negedge clk_i);
    check("bp_17th_blocked", in_ready_o, 1'b0);
    @(negedge clk_i);
    check("bp_a_stable", out_data_o, pack(64'h100, 8));
    check("bp_a_mask_stable", out_mask_o, 8'hFF);
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b1;
    tick();
    check("bp_b_valid", out_valid_o, 1'b1);
    check("bp_b_data", out_data_o, pack(64'h200, 8));
    check("bp_reopen", in_ready_o, 1'b1);
    tick();
    in_valid_i = 1'b0;
    check("bp_b_consumed", out_valid_o, 1'b0);
    pulse_flush();
    check("bp_c_mask", out_mask_o, 8'h01);
    check("bp_c_data", out_data_o, pack(64'hC0, 1));
    tick();

    // Flush together with the 5th beat
    send_n(64'hDEAD_0000, 4);
    in_valid_i = 1'b1;
    in_data_i  = 64'hDEAD_0004;
    flush_i    = 1'b1;
    tick();
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    check("sameflush_valid", out_valid_o, 1'b1);
    check("sameflush_mask", out_mask_o, 8'h1F);
    check("sameflush_data", out_data_o, pack(64'hDEAD_0000, 5));
    tick();

    // Idle behaviour after 2 beats
    send_n(64'h55, 2);
`ifdef STREAM_PACKER_TIMEOUT_EN
    lat = 0;
    while (!out_valid_o && lat < 40) begin
      tick();
      lat++;
    end
    check("timeout_latency", lat, 16);
    check("timeout_mask", out_mask_o, 8'h03);
    check("timeout_data", out_data_o, pack(64'h55, 2));
    tick();
`else
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (out_valid_o) seen = 1'b1;
    end
    lat = 0;
    check("no_timeout_out", seen, 1'b0);
    pulse_flush();
    check("manual_flush_mask", out_mask_o, 8'h03);
    check("manual_flush_data", out_data_o, pack(64'h55, 2));
    tick();
`endif

    // Reset mid-word
    send_n(64'h900, 4);
    rst_ni = 1'b0;
    #2;
    check("midrst_valid", out_valid_o, 1'b0);
    check("midrst_ready", in_ready_o, 1'b0);
    check("midrst_mask", out_mask_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    check("midrst_ready_back", in_ready_o, 1'b1);
    tick();
    tick();
    check("midrst_no_emit", out_valid_o, 1'b0);
    send_n(64'h300, 8);
    check("fresh_valid", out_valid_o, 1'b1);
    check("fresh_mask", out_mask_o, 8'hFF);
    check("fresh_data", out_data_o, pack(64'h300, 8));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
